// File: rtl/card_writer.sv
// Card issuance encoder: latches {account_info, acc_addr} and writes it to the stripe head
// as a framed stream: start sentinel 1011, 21 data bits MSB-first, odd parity, end sentinel 1111.
module card_writer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Insert_Card,
    input  logic        write_req,
    input  logic [15:0] account_info,
    input  logic [4:0]  acc_addr,
    output logic        stripe_data,
    output logic        stripe_en,
    output logic        bit_strobe,
    output logic        busy,
    output logic        write_done,
    output logic        write_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_END    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [7:0] CNT_MAX  = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] SENTINEL = 4'b1011;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [20:0] shreg_q, shreg_d;
    logic        par_q, par_d;

    logic        sdata_q, sdata_d;
    logic        sen_q, sen_d;
    logic        strobe_q, strobe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        bit_end, last_bit, in_frame_d;
    logic [2:0]  adv_state;

    always_comb begin
        last_bit  = 1'b0;
        adv_state = S_IDLE;
        case (state_q)
            S_START:  begin last_bit = (idx_q == 5'd3);  adv_state = S_DATA;   end
            S_DATA:   begin last_bit = (idx_q == 5'd20); adv_state = S_PARITY; end
            S_PARITY: begin last_bit = 1'b1;             adv_state = S_END;    end
            S_END:    begin last_bit = (idx_q == 5'd3);  adv_state = S_DONE;   end
            default:  begin last_bit = 1'b0;             adv_state = S_IDLE;   end
        endcase
    end

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (write_req) begin
                    if (Insert_Card) begin
                        state_d = S_START;
                        shreg_d = {account_info, acc_addr};
                        par_d   = ~^{account_info, acc_addr};
                        cnt_d   = 8'd0;
                        idx_d   = 5'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_START, S_DATA, S_PARITY, S_END: begin
                // Pulling the card mid-frame drops straight back to idle with an error pulse.
                if (!Insert_Card) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    idx_d   = 5'd0;
                    err_d   = 1'b1;
                end else if (!bit_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (state_q == S_DATA)
                        shreg_d = {shreg_q[19:0], 1'b0};
                    if (last_bit) begin
                        state_d = adv_state;
                        idx_d   = 5'd0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                idx_d   = 5'd0;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they register in step with the state.
    always_comb begin
        in_frame_d = (state_d == S_START) || (state_d == S_DATA) ||
                     (state_d == S_PARITY) || (state_d == S_END);
        case (state_d)
            S_START:  sdata_d = SENTINEL[~idx_d[1:0]];
            S_DATA:   sdata_d = shreg_d[20];
            S_PARITY: sdata_d = par_d;
            S_END:    sdata_d = 1'b1;
            default:  sdata_d = 1'b0;
        endcase
        sen_d    = in_frame_d;
        strobe_d = in_frame_d && (cnt_d == 8'd0);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 5'd0;
            shreg_q  <= 21'd0;
            par_q    <= 1'b0;
            sdata_q  <= 1'b0;
            sen_q    <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            sdata_q  <= sdata_d;
            sen_q    <= sen_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign stripe_data = sdata_q;
    assign stripe_en   = sen_q;
    assign busy        = sen_q;
    assign bit_strobe  = strobe_q;
    assign write_done  = done_q;
    assign write_error = err_q;

endmodule
